// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: instruction memory request/response and decode handshake.
// master = ifetch, slave = memory and decode side.
interface ifetch_if;
    logic        imem_req_out;
    logic [15:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [15:0] imem_rdata_in;
    logic        ir_valid_out;
    logic [15:0] ir_out;
    logic [15:0] ir_pc_out;
    logic        ir_ready_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_gnt_in,
        input  imem_rvalid_in,
        input  imem_rdata_in,
        output ir_valid_out,
        output ir_out,
        output ir_pc_out,
        input  ir_ready_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_gnt_in,
        output imem_rvalid_in,
        output imem_rdata_in,
        input  ir_valid_out,
        input  ir_out,
        input  ir_pc_out,
        output ir_ready_in
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory read, DEPTH-entry instruction FIFO.
// Ports: clk, rst_n, pc_in, ps_out (PC select), redir_rel_in, redir_abs_in, bus (ifetch_if.master).
module ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_in,
    output logic [1:0]  ps_out,
    input  logic        redir_rel_in,
    input  logic        redir_abs_in,
    ifetch_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

    state_t          state;
    logic [15:0]     tag;
    logic [15:0]     buf_d [DEPTH];
    logic [15:0]     buf_p [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic redir;
    logic req;
    logic accept;
    logic push;
    logic pop;
    logic valid;

    assign redir  = redir_rel_in | redir_abs_in;
    assign req    = (state == REQ) && (count < CW'(DEPTH)) && !redir;
    assign accept = req & bus.imem_gnt_in;
    assign valid  = (count != '0);
    // A redirect squashes both ends of the FIFO; the flush wins.
    assign push   = (state == WAIT) && bus.imem_rvalid_in && !redir;
    assign pop    = valid && bus.ir_ready_in && !redir;

    assign bus.imem_req_out  = req;
    assign bus.imem_addr_out = (state == REQ) ? pc_in : '0;
    assign bus.ir_valid_out  = valid;
    assign bus.ir_out        = valid ? buf_d[rd_ptr] : '0;
    assign bus.ir_pc_out     = valid ? buf_p[rd_ptr] : '0;

    // Gated by rst_n so the PC register sees "hold" throughout reset.
    always_comb begin
        ps_out = 2'b00;
        if (!rst_n)
            ps_out = 2'b00;
        else if (redir_abs_in)
            ps_out = 2'b11;
        else if (redir_rel_in)
            ps_out = 2'b10;
        else if (accept)
            ps_out = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tag   <= '0;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (accept) begin
                        tag   <= pc_in;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid_in)
                        state <= REQ;
                    else if (redir)
                        state <= KILL;
                end
                KILL: begin
                    if (bus.imem_rvalid_in)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redir) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_d[wr_ptr] <= bus.imem_rdata_in;
            buf_p[wr_ptr] <= tag;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a queue-based fetch model.
// Directed scenarios pin the model with literal expectations.
module tb_ifetch;
    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] d;
        logic [15:0] p;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_in = '0;
    logic [1:0]  ps_out;
    logic        redir_rel_in = 1'b0;
    logic        redir_abs_in = 1'b0;

    ifetch_if bus ();

    ifetch #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_in(pc_in),
        .ps_out(ps_out),
        .redir_rel_in(redir_rel_in),
        .redir_abs_in(redir_abs_in),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model of fetch unit
    ent_t        q[$];
    bit          m_idle;
    bit          m_busy;
    bit          m_killed;
    logic [15:0] m_tag;

    // memory and PC register environment
    bit          mem_pend;
    int          mem_cnt;
    logic [15:0] mem_addr;
    logic [15:0] pc;
    logic [15:0] rel_off = 16'h0010;
    logic [15:0] abs_tgt = 16'h0100;
    bit          rel_pending;

    // samples of the last step
    logic [1:0]  s_ps;
    logic        s_req;
    logic [15:0] s_addr;
    logic        s_valid;
    logic [15:0] s_ir;
    logic [15:0] s_irpc;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic do_reset(input logic [15:0] pc0);
        @(negedge clk);
        rst_n = 1'b0;
        redir_rel_in = 1'($urandom);
        redir_abs_in = 1'($urandom);
        bus.imem_rvalid_in = 1'b0;
        #1;
        chk("rst_ps", ps_out, 0);
        chk("rst_req", bus.imem_req_out, 0);
        chk("rst_addr", bus.imem_addr_out, 0);
        chk("rst_valid", bus.ir_valid_out, 0);
        chk("rst_ir", bus.ir_out, 0);
        chk("rst_irpc", bus.ir_pc_out, 0);
        q.delete();
        m_idle   = 1'b1;
        m_busy   = 1'b0;
        m_killed = 1'b0;
        m_tag    = '0;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        pc       = pc0;
        repeat (2) @(posedge clk);
        rel_pending = 1'b1;
    endtask

    task automatic step(input bit gnt, input bit rdy, input bit rel,
                        input bit abs_j, input int lat);
        bit          redir;
        bit          e_req;
        bit          e_valid;
        bit          acc;
        bit          push;
        bit          pop;
        bit          rv;
        logic [15:0] rd;
        logic [1:0]  e_ps;
        @(negedge clk);
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 1'b0;
        end
        bus.imem_gnt_in = gnt;
        bus.ir_ready_in = rdy;
        redir_rel_in = rel;
        redir_abs_in = abs_j;
        pc_in = pc;
        rv = mem_pend && (mem_cnt == 0);
        rd = rv ? (mem_addr ^ 16'hA5A5) : 16'($urandom);
        bus.imem_rvalid_in = rv;
        bus.imem_rdata_in = rd;
        #1;
        redir   = rel | abs_j;
        e_req   = !m_idle && !m_busy && (q.size() < DEPTH) && !redir;
        acc     = e_req && gnt;
        e_ps    = abs_j ? 2'd3 : rel ? 2'd2 : acc ? 2'd1 : 2'd0;
        e_valid = (q.size() != 0);
        s_ps    = ps_out;
        s_req   = bus.imem_req_out;
        s_addr  = bus.imem_addr_out;
        s_valid = bus.ir_valid_out;
        s_ir    = bus.ir_out;
        s_irpc  = bus.ir_pc_out;
        chk("ps", s_ps, e_ps);
        chk("req", s_req, e_req);
        if (e_req)
            chk("addr", s_addr, pc);
        chk("valid", s_valid, e_valid);
        if (e_valid) begin
            chk("ir", s_ir, q[0].d);
            chk("irpc", s_irpc, q[0].p);
        end
        push = m_busy && rv && !m_killed && !redir;
        pop  = e_valid && rdy && !redir;
        if (pop)
            void'(q.pop_front());
        if (push)
            q.push_back('{d: rd, p: m_tag});
        if (redir)
            q.delete();
        if (m_idle)
            m_idle = 1'b0;
        else if (!m_busy) begin
            if (acc) begin
                m_busy = 1'b1;
                m_tag  = pc;
            end
        end else if (rv) begin
            m_busy   = 1'b0;
            m_killed = 1'b0;
        end else if (redir)
            m_killed = 1'b1;
        if (rv)
            mem_pend = 1'b0;
        else if (mem_pend)
            mem_cnt--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = lat;
            mem_addr = pc;
        end
        case (e_ps)
            2'd1:    pc = pc + 16'd1;
            2'd2:    pc = pc + rel_off;
            2'd3:    pc = abs_tgt;
            default: pc = pc;
        endcase
        @(posedge clk);
    endtask

    initial begin
        int rprob;
        bus.imem_gnt_in = 1'b0;
        bus.imem_rvalid_in = 1'b0;
        bus.imem_rdata_in = '0;
        bus.ir_ready_in = 1'b0;

        // streaming, one instruction every two cycles
        do_reset(16'h0000);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("s034_ps", s_ps, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("s034_v0", s_valid, 1);
        chk("s034_pc0", s_irpc, 16'h0000);
        chk("s034_ir0", s_ir, 16'hA5A5);
        step(1, 1, 0, 0, 0);
        chk("s034_gap", s_valid, 0);
        step(1, 1, 0, 0, 0);
        chk("s034_pc1", s_irpc, 16'h0001);
        chk("s034_ir1", s_ir, 16'hA5A4);
        repeat (6) step(1, 1, 0, 0, 0);

        // full buffer stalls fetch
        do_reset(16'h0000);
        repeat (8) step(1, 0, 0, 0, 0);
        chk("s035_req", s_req, 0);
        chk("s035_ps", s_ps, 0);
        chk("s035_pc", s_irpc, 16'h0000);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("s035_pc1", s_irpc, 16'h0001);
        chk("s035_ir1", s_ir, 16'hA5A4);
        chk("s035_ps1", s_ps, 1);

        // relative redirect while waiting
        do_reset(16'h0005);
        step(1, 1, 0, 0, 2);
        step(1, 1, 0, 0, 2);
        chk("s036_addr", s_addr, 16'h0005);
        step(0, 1, 1, 0, 0);
        chk("s036_ps", s_ps, 2);
        step(1, 1, 0, 0, 0);
        chk("s036_kill", s_req, 0);
        step(1, 1, 0, 0, 0);
        chk("s036_drop", s_req, 0);
        step(1, 1, 0, 0, 0);
        chk("s036_newaddr", s_addr, 16'h0016);
        chk("s036_empty", s_valid, 0);

        // both redirects with push and pop in the same cycle
        do_reset(16'h0000);
        abs_tgt = 16'h0100;
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("s037_ps", s_ps, 3);
        step(0, 1, 0, 0, 0);
        chk("s037_empty", s_valid, 0);
        chk("s037_addr", s_addr, 16'h0100);

        // grant withheld
        do_reset(16'h0040);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("s038_req", s_req, 1);
            chk("s038_addr", s_addr, 16'h0040);
            chk("s038_ps", s_ps, 0);
        end
        step(1, 1, 0, 0, 1);
        chk("s038_grant", s_ps, 1);

        // reset while waiting with one entry buffered
        do_reset(16'h0000);
        repeat (7) step(1, 0, 0, 0, 2);
        do_reset(16'h0000);
        step(0, 1, 0, 0, 0);
        chk("s039_v0", s_valid, 0);
        step(0, 1, 0, 0, 0);
        chk("s039_v1", s_valid, 0);

        // randomized traffic
        rprob = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0)
                rprob = $urandom_range(10, 95);
            if ($urandom_range(0, 399) == 0)
                do_reset(16'($urandom));
            abs_tgt = 16'($urandom);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < rprob,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
